seg_text_scheduler: RTL and testbench

//   Character buffer and display sequencer for the 7-seg text path. Accepts ASCII

---
 rtl/seg_text_scheduler.sv | 151 +++++++++++++++
 tb/tb_seg_text_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_text_scheduler.sv
// Character buffer and sequencer for the 7-segment text path: keeps the newest DIGITS
// characters, handles scroll, backspace, ESC flush and idle blanking.
module seg_text_scheduler #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned IDLE_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             char_valid,
  input  logic [7:0]                       char_code,
  output logic                             char_ready,
  output logic [8*DIGITS-1:0]              digit_code,
  output logic [DIGITS-1:0]                digit_en,
  output logic [$clog2(DIGITS+1)-1:0]      char_count,
  output logic                             sleeping
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned TW = (IDLE_CYCLES == 0) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam int unsigned IW = $clog2(DIGITS);

  localparam logic [CW-1:0] CountMax  = CW'(DIGITS);
  localparam logic [TW-1:0] TimerLast = (IDLE_CYCLES == 0) ? '0 : TW'(IDLE_CYCLES - 1);
  localparam logic [IW-1:0] FlushTop  = IW'(DIGITS - 1);

  localparam logic [7:0] CharBs  = 8'h08;
  localparam logic [7:0] CharEsc = 8'h1B;

  typedef enum logic [1:0] {StEmpty, StShow, StSleep, StFlush} state_e;

  state_e            state_q, state_d;
  logic [7:0]        slot_q [DIGITS];
  logic [7:0]        slot_d [DIGITS];
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IW-1:0]     fidx_q, fidx_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic              ready_q, ready_d;
  logic              sleep_q, sleep_d;

  logic accept;
  logic is_print;

  assign accept   = char_valid && ready_q;
  assign is_print = (char_code >= 8'h20) && (char_code <= 8'h7E);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    count_d = count_q;
    fidx_d  = fidx_q;

    unique case (state_q)
      StFlush: begin
        slot_d[fidx_q] = 8'h00;
        if (fidx_q == '0) begin
          state_d = StEmpty;
        end else begin
          fidx_d = fidx_q - 1'b1;
        end
      end
      default: begin
        if (accept) begin
          if (is_print) begin
            for (int i = DIGITS - 1; i > 0; i--) begin
              slot_d[i] = slot_q[i-1];
            end
            slot_d[0] = char_code;
            if (count_q != CountMax) begin
              count_d = count_q + 1'b1;
            end
            state_d = StShow;
          end else if (char_code == CharBs) begin
            // Backspace in EMPTY is a no-op; count never underflows.
            if (count_q != '0) begin
              for (int i = 0; i < DIGITS - 1; i++) begin
                slot_d[i] = slot_q[i+1];
              end
              slot_d[DIGITS-1] = 8'h00;
              count_d          = count_q - 1'b1;
              state_d          = (count_q == CW'(1)) ? StEmpty : StShow;
            end
          end else if (char_code == CharEsc) begin
            state_d = StFlush;
            count_d = '0;
            fidx_d  = FlushTop;
          end else if (state_q == StSleep) begin
            state_d = StShow;
          end
        end else if ((IDLE_CYCLES != 0) && (state_q == StShow) && (timer_q == TimerLast)) begin
          state_d = StSleep;
        end
      end
    endcase
  end

  // Timer restarts on any accept or state change and only advances while showing.
  always_comb begin
    timer_d = '0;
    if (!accept && (state_d == state_q) && (state_q == StShow)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    ready_d = (state_d != StFlush);
    sleep_d = (state_d == StSleep);
    en_d    = '0;
    if (state_d == StShow) begin
      for (int i = 0; i < DIGITS; i++) begin
        en_d[i] = (CW'(i) < count_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      for (int i = 0; i < DIGITS; i++) begin
        slot_q[i] <= 8'h00;
      end
      count_q <= '0;
      timer_q <= '0;
      fidx_q  <= '0;
      en_q    <= '0;
      ready_q <= 1'b1;
      sleep_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      count_q <= count_d;
      timer_q <= timer_d;
      fidx_q  <= fidx_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      sleep_q <= sleep_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      digit_code[8*i +: 8] = slot_q[i];
    end
  end

  assign digit_en   = en_q;
  assign char_count = count_q;
  assign char_ready = ready_q;
  assign sleeping   = sleep_q;

endmodule

// File: tb/tb_seg_text_scheduler.sv
// Bench for seg_text_scheduler: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_seg_text_scheduler;

  localparam int unsigned D  = 8;
  localparam int unsigned IC = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             char_valid;
  logic [7:0]       char_code;
  logic             char_ready;
  logic [8*D-1:0]   digit_code;
  logic [D-1:0]     digit_en;
  logic [3:0]       char_count;
  logic             sleeping;

  seg_text_scheduler #(.DIGITS(D), .IDLE_CYCLES(IC)) dut (
    .clk       (clk),
    .rst       (rst),
    .char_valid(char_valid),
    .char_code (char_code),
    .char_ready(char_ready),
    .digit_code(digit_code),
    .digit_en  (digit_en),
    .char_count(char_count),
    .sleeping  (sleeping)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0 empty, 1 showing, 2 asleep, 3 flushing.
  logic [7:0] m_slot [D];
  int         m_count;
  int         m_mode;
  int         m_idle;
  int         m_fidx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_slot[i] = 8'h00;
    m_count = 0;
    m_mode  = 0;
    m_idle  = 0;
    m_fidx  = 0;
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] c);
    bit acc;
    if (r) begin
      model_reset();
      return;
    end
    acc = v && (m_mode != 3);
    if (m_mode == 3) begin
      m_slot[m_fidx] = 8'h00;
      if (m_fidx == 0) m_mode = 0;
      else m_fidx--;
    end else if (acc) begin
      m_idle = 0;
      if (c >= 8'h20 && c <= 8'h7E) begin
        for (int i = D - 1; i > 0; i--) m_slot[i] = m_slot[i-1];
        m_slot[0] = c;
        if (m_count < D) m_count++;
        m_mode = 1;
      end else if (c == 8'h08) begin
        if (m_count > 0) begin
          for (int i = 0; i < D - 1; i++) m_slot[i] = m_slot[i+1];
          m_slot[D-1] = 8'h00;
          m_count--;
          m_mode = (m_count == 0) ? 0 : 1;
        end
      end else if (c == 8'h1B) begin
        m_mode  = 3;
        m_count = 0;
        m_fidx  = D - 1;
      end else if (m_mode == 2) begin
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (m_idle == IC - 1) begin
        m_mode = 2;
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end
  endtask

  task automatic check_model();
    logic [63:0] exp_code;
    logic [63:0] exp_en;
    exp_code = '0;
    for (int i = 0; i < D; i++) exp_code[8*i +: 8] = m_slot[i];
    exp_en = (m_mode == 1) ? ((64'd1 << m_count) - 64'd1) : 64'd0;
    chk("digit_code", 64'(digit_code), exp_code);
    chk("digit_en",   64'(digit_en),   exp_en);
    chk("char_count", 64'(char_count), 64'(m_count));
    chk("char_ready", 64'(char_ready), 64'(m_mode != 3));
    chk("sleeping",   64'(sleeping),   64'(m_mode == 2));
  endtask

  // Called at a negedge: drive, advance the model over the next edge, then check.
  task automatic cyc(input logic r, input logic v, input logic [7:0] c);
    rst        = r;
    char_valid = v;
    char_code  = c;
    model_step(r, v, c);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic push(input logic [7:0] c);
    cyc(1'b0, 1'b1, c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int sel;
    logic [7:0] c;

    model_reset();
    rst = 1'b1; char_valid = 1'b0; char_code = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_model();
    chk("reset_ready", 64'(char_ready), 64'd1);

    // 1: 'H','I'
    cyc(1'b0, 1'b0, 8'h00);
    push(8'h48);
    chk("hi_count1", 64'(char_count), 64'd1);
    push(8'h49);
    chk("hi_code", 64'(digit_code[15:0]), 64'h4849);
    chk("hi_en",   64'(digit_en), 64'h03);
    chk("hi_count", 64'(char_count), 64'd2);

    // 2: scroll
    cyc(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 10; k++) push(8'h30 + 8'(k));
    chk("scroll_code", 64'(digit_code), 64'h3233343536373839);
    chk("scroll_en", 64'(digit_en), 64'hFF);
    chk("scroll_count", 64'(char_count), 64'd8);

    // 3: backspace
    cyc(1'b1, 1'b0, 8'h00);
    push(8'h41); push(8'h42); push(8'h43);
    push(8'h08); push(8'h08);
    chk("bs_code", 64'(digit_code), 64'h41);
    chk("bs_en", 64'(digit_en), 64'h01);
    push(8'h08);
    chk("bs_empty_en", 64'(digit_en), 64'h00);
    chk("bs_empty_count", 64'(char_count), 64'd0);
    push(8'h08);
    chk("bs_noop_code", 64'(digit_code), 64'h0);
    chk("bs_noop_count", 64'(char_count), 64'd0);

    // 4: flush with valid held high
    cyc(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) push(8'h31 + 8'(k));
    push(8'h1B);
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      if (char_ready) break;
      lows++;
      push(8'h58);
    end
    chk("flush_low_cycles", 64'(lows), 64'd8);
    chk("flush_code", 64'(digit_code), 64'h0);
    chk("flush_count", 64'(char_count), 64'd0);
    idle(1);

    // 5: idle blanking
    cyc(1'b1, 1'b0, 8'h00);
    push(8'h51);
    idle(3);
    chk("awake_before", 64'(sleeping), 64'd0);
    idle(1);
    chk("asleep", 64'(sleeping), 64'd1);
    chk("asleep_en", 64'(digit_en), 64'h00);
    chk("asleep_slot0", 64'(digit_code[7:0]), 64'h51);
    push(8'h5A);
    chk("wake_code", 64'(digit_code[15:0]), 64'h515A);
    chk("wake_en", 64'(digit_en), 64'h03);
    chk("wake_sleep", 64'(sleeping), 64'd0);

    // 6: reset mid-flush, mid-show, and an ignored char restarting the timer
    push(8'h1B);
    idle(3);
    cyc(1'b1, 1'b0, 8'h00);
    chk("rst_flush_ready", 64'(char_ready), 64'd1);
    chk("rst_flush_code", 64'(digit_code), 64'h0);
    cyc(1'b0, 1'b0, 8'h00);
    push(8'h41); push(8'h42);
    cyc(1'b1, 1'b0, 8'h00);
    chk("rst_show_en", 64'(digit_en), 64'h00);
    chk("rst_show_count", 64'(char_count), 64'd0);
    cyc(1'b0, 1'b0, 8'h00);
    push(8'h41);
    idle(2);
    push(8'h07);
    idle(3);
    chk("bel_awake", 64'(sleeping), 64'd0);
    chk("bel_slot0", 64'(digit_code[7:0]), 64'h41);
    idle(1);
    chk("bel_asleep", 64'(sleeping), 64'd1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 50)      c = 8'($urandom_range(8'h20, 8'h7E));
      else if (sel < 65) c = 8'h08;
      else if (sel < 69) c = 8'h1B;
      else               c = 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 60), c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
